io_bus_dma_master: RTL and testbench

- Bus initiator for the memory-router IO bus: the active end of the protocol that io register responders answer.
- Copies a block of bytes from {source high byte, 8'h00} to a fixed destination region (default OAM, 16'hFE00..16'hFE9F). Each byte takes one read cycle followed by one write cycle.
- Sits beside the CPU on the router's arbitrated master port; started by the DMA io register's write strobe.

---
 rtl/io_bus_pkg.sv | 21 ++
 rtl/io_bus_dma_master.sv | 107 ++++++++++
 tb/tb_io_bus_dma_master.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// Shared IO bus definitions: DMA state encoding, responder mode codes, fixed map addresses.
package io_bus_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_READ  = 2'd1,
    DMA_WRITE = 2'd2
  } dma_state_e;

  localparam logic [1:0]  READ_ONLY    = 2'b10;
  localparam logic [1:0]  WRITE_ONLY   = 2'b01;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_DMA_LEN  = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  // Byte offset into a 64K window; wraps modulo 2^16.
  function automatic logic [15:0] dma_addr(input logic [15:0] base, input logic [7:0] idx);
    return base + {8'h00, idx};
  endfunction

endpackage

// File: rtl/io_bus_dma_master.sv
// IO bus DMA initiator: copies P_LENGTH bytes from {src,8'h00} to P_DST_BASE, one read + one write per byte.
// Optional IO_DMA_RESTART_EN: a start strobe while busy restarts the transfer with the new source.
module io_bus_dma_master
  import io_bus_pkg::*;
#(
  parameter logic [15:0] P_DST_BASE = OAM_BASE,
  parameter int          P_LENGTH   = OAM_DMA_LEN
) (
  input  logic        I_CLK,
  input  logic        I_RESET_L,
  input  logic        I_START,
  input  logic [7:0]  I_SRC_HIGH,
  input  logic        I_BUS_GRANT,
  output logic        O_BUS_REQ,
  output logic [15:0] O_ADDR_BUS,
  output logic        O_WE_BUS_L,
  output logic        O_RE_BUS_L,
  inout  wire  [7:0]  IO_DATA_BUS,
  output logic        O_BUSY,
  output logic        O_DONE
);

  localparam logic [7:0] LP_LAST = 8'(P_LENGTH - 1);

  dma_state_e  r_state, w_next;
  logic [7:0]  r_idx, r_src, r_data;
  logic        r_done;
  logic        w_take_start, w_rd_fire, w_wr_fire, w_last;
  logic [15:0] w_addr;
  logic        w_re_l, w_we_l, w_drive;

`ifdef IO_DMA_RESTART_EN
  assign w_take_start = I_START;
`else
  assign w_take_start = I_START && (r_state == DMA_IDLE);
`endif

  assign w_rd_fire = (r_state == DMA_READ)  && I_BUS_GRANT;
  assign w_wr_fire = (r_state == DMA_WRITE) && I_BUS_GRANT;
  assign w_last    = w_wr_fire && (r_idx == LP_LAST);

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) r_state <= DMA_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_take_start) begin
      w_next = DMA_READ;
    end else begin
      case (r_state)
        DMA_READ:  if (I_BUS_GRANT) w_next = DMA_WRITE;
        DMA_WRITE: if (I_BUS_GRANT) w_next = w_last ? DMA_IDLE : DMA_READ;
        default:   w_next = r_state;
      endcase
    end
  end

  // A restart landing on the final write edge wins, so no done pulse for that transfer.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      r_idx  <= 8'h00;
      r_src  <= 8'h00;
      r_data <= 8'h00;
      r_done <= 1'b0;
    end else begin
      if (w_take_start) begin
        r_src <= I_SRC_HIGH;
        r_idx <= 8'h00;
      end else if (w_wr_fire && !w_last) begin
        r_idx <= r_idx + 8'd1;
      end
      if (w_rd_fire) r_data <= IO_DATA_BUS;
      r_done <= w_last && !w_take_start;
    end
  end

  // Strobes follow grant combinationally so a lost grant releases the bus in the same cycle.
  always_comb begin
    w_addr  = 16'h0000;
    w_re_l  = 1'b1;
    w_we_l  = 1'b1;
    w_drive = 1'b0;
    case (r_state)
      DMA_READ: begin
        w_addr = dma_addr({r_src, 8'h00}, r_idx);
        w_re_l = ~I_BUS_GRANT;
      end
      DMA_WRITE: begin
        w_addr  = dma_addr(P_DST_BASE, r_idx);
        w_we_l  = ~I_BUS_GRANT;
        w_drive = I_BUS_GRANT;
      end
      default: ;
    endcase
  end

  assign IO_DATA_BUS = w_drive ? r_data : 8'hzz;
  assign O_ADDR_BUS  = w_addr;
  assign O_RE_BUS_L  = w_re_l;
  assign O_WE_BUS_L  = w_we_l;
  assign O_BUSY      = (r_state != DMA_IDLE);
  assign O_BUS_REQ   = (r_state != DMA_IDLE);
  assign O_DONE      = r_done;

endmodule

// File: tb/tb_io_bus_dma_master.sv
// Bench for io_bus_dma_master: default OAM instance plus a 256-byte instance whose destination wraps past FFFF.
// Build with IO_DMA_RESTART_EN defined to exercise the restart expectations.
module tb_io_bus_dma_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start0, start1, grant0, grant1;
  logic [7:0]  src_high;
  wire  [7:0]  dbus0, dbus1;
  logic [15:0] addr0, addr1;
  logic        re0, re1, we0, we1, req0, req1, busy0, busy1, done0, done1;

  logic [7:0] mem [2][65536];

  // Responders drive read data combinationally while the read strobe is low.
  assign dbus0 = (!re0) ? mem[0][addr0] : 8'hzz;
  assign dbus1 = (!re1) ? mem[1][addr1] : 8'hzz;

  io_bus_dma_master u_dut0 (
    .I_CLK(clk), .I_RESET_L(rst_n), .I_START(start0), .I_SRC_HIGH(src_high),
    .I_BUS_GRANT(grant0), .O_BUS_REQ(req0), .O_ADDR_BUS(addr0), .O_WE_BUS_L(we0),
    .O_RE_BUS_L(re0), .IO_DATA_BUS(dbus0), .O_BUSY(busy0), .O_DONE(done0)
  );

  io_bus_dma_master #(.P_DST_BASE(16'hFF80), .P_LENGTH(256)) u_dut1 (
    .I_CLK(clk), .I_RESET_L(rst_n), .I_START(start1), .I_SRC_HIGH(src_high),
    .I_BUS_GRANT(grant1), .O_BUS_REQ(req1), .O_ADDR_BUS(addr1), .O_WE_BUS_L(we1),
    .O_RE_BUS_L(re1), .IO_DATA_BUS(dbus1), .O_BUSY(busy1), .O_DONE(done1)
  );

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] src; int drop_idx; int drop_len; int exp_busy; } vec_t;

  logic [15:0] rq[$];
  wr_t         wq[$];

  int n_tests = 0, n_fail = 0;
  int cur, cyc, bcnt, dcnt, dcyc, rcnt, wcnt;
  int drop_idx, drop_len, drop_left, inj_idx, rst_idx;
  logic inj_pending, rst_pending, aborted, g;
  logic [7:0] inj_src;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Sequential reference copy: each byte sees earlier writes, matching read-before-write order.
  task automatic push_xfer(input logic [7:0] s, input int len, input logic [15:0] dst);
    logic [7:0] ov [int];
    logic [15:0] ra, wa;
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      ra = {s, 8'h00} + 16'(i);
      d  = ov.exists(int'(ra)) ? ov[int'(ra)] : mem[cur][ra];
      wa = dst + 16'(i);
      ov[int'(wa)] = d;
      rq.push_back(ra);
      wq.push_back('{a: wa, d: d});
    end
  endtask

  task automatic observe();
    logic b, dn, re, we;
    logic [15:0] a, ea;
    logic [7:0] dv;
    wr_t w;
    b  = cur ? busy1 : busy0;
    dn = cur ? done1 : done0;
    re = cur ? re1 : re0;
    we = cur ? we1 : we0;
    a  = cur ? addr1 : addr0;
    dv = cur ? dbus1 : dbus0;
    cyc++;
    if (b) bcnt++;
    if (dn) begin dcnt++; dcyc = cyc; end
    chk("strobe_excl", re | we, 1'b1);
    if (!g && b) begin
      chk("stall_we_l", we, 1'b1);
      chk("stall_re_l", re, 1'b1);
    end
    if (!re) begin
      if (rq.size() == 0) fail("rd_unexpected", a, 0);
      else begin ea = rq.pop_front(); chk("rd_addr", a, ea); end
      if (rcnt == drop_idx) drop_left = drop_len;
      if (rcnt == inj_idx)  inj_pending = 1'b1;
      if (rcnt == rst_idx)  rst_pending = 1'b1;
      rcnt++;
    end
    if (!we) begin
      if (wq.size() == 0) fail("wr_unexpected", a, 0);
      else begin
        w = wq.pop_front();
        chk("wr_addr", a, w.a);
        chk("wr_data", dv, w.d);
      end
      mem[cur][a] = dv;
      wcnt++;
    end
  endtask

  task automatic step(input logic st, input logic [7:0] sh);
    @(negedge clk);
    if (drop_left > 0) begin g = 1'b0; drop_left--; end
    else g = 1'b1;
    grant0   = g;
    grant1   = g;
    start0   = (cur == 0) && st;
    start1   = (cur == 1) && st;
    src_high = sh;
    #1;
    observe();
  endtask

  task automatic run_xfer(input logic [7:0] s, input int len, input logic [15:0] dst);
    logic fin, inj;
    cyc = -1; bcnt = 0; dcnt = 0; dcyc = 0; rcnt = 0; wcnt = 0;
    drop_left = 0; inj_pending = 0; rst_pending = 0; aborted = 0; fin = 0;
    push_xfer(s, len, dst);
    step(1'b1, s);
    for (int n = 0; n < 1500; n++) begin
      inj = inj_pending;
      inj_pending = 1'b0;
      step(inj, inj_src);
      if (inj) begin
`ifdef IO_DMA_RESTART_EN
        rq.delete();
        wq.delete();
        push_xfer(inj_src, len, dst);
`endif
      end
      if (rst_pending) begin
        rst_pending = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy0, 1'b0);
        chk("arst_req", req0, 1'b0);
        chk("arst_re_l", re0, 1'b1);
        chk("arst_we_l", we0, 1'b1);
        chk("arst_addr", addr0, 16'h0000);
        chk("arst_done", done0, 1'b0);
        aborted = 1'b1;
        break;
      end
      if (!(cur ? busy1 : busy0)) begin fin = 1'b1; break; end
    end
    if (!aborted) begin
      if (!fin) fail("xfer_timeout", bcnt, len * 2);
      step(1'b0, 8'h00);
      chk("sb_rd_left", rq.size(), 0);
      chk("sb_wr_left", wq.size(), 0);
    end
  endtask

  task automatic init_src(input int d, input logic [7:0] s, input logic [7:0] key);
    for (int i = 0; i < 256; i++) mem[d][{s, 8'h00} + 16'(i)] = 8'(i) ^ key;
  endtask

  task automatic fill(input int d, input logic [15:0] base, input int len, input logic [7:0] v);
    for (int i = 0; i < len; i++) mem[d][base + 16'(i)] = v;
  endtask

  task automatic chk_dest(input string name, input logic [15:0] base, input int lo, input int hi,
                          input logic [7:0] key, input logic pattern);
    int errs;
    logic [7:0] e;
    errs = 0;
    for (int i = lo; i < hi; i++) begin
      e = pattern ? (8'(i) ^ key) : key;
      if (mem[0][base + 16'(i)] !== e) errs++;
    end
    chk(name, errs, 0);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{src: 8'hC0, drop_idx: -1,  drop_len: 0, exp_busy: 320};
    vecs[1] = '{src: 8'hC0, drop_idx: 10,  drop_len: 3, exp_busy: 323};
    vecs[2] = '{src: 8'hA3, drop_idx: 0,   drop_len: 1, exp_busy: 321};
    vecs[3] = '{src: 8'hC0, drop_idx: 159, drop_len: 2, exp_busy: 322};

    cur = 0; g = 1'b1; drop_idx = -1; drop_len = 0; inj_idx = -1; rst_idx = -1; inj_src = 8'h00;
    start0 = 0; start1 = 0; grant0 = 1; grant1 = 1; src_high = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy0, 1'b0);
    chk("rst_req", req0, 1'b0);
    chk("rst_re_l", re0, 1'b1);
    chk("rst_we_l", we0, 1'b1);
    chk("rst_addr", addr0, 16'h0000);
    chk("rst_done", done0, 1'b0);
    chk("rst_busy_b", busy1, 1'b0);
    // Start during reset must be lost.
    @(negedge clk); start0 = 1'b1; src_high = 8'hC0;
    @(negedge clk); start0 = 1'b0;
    chk("rst_vs_start", busy0, 1'b0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      init_src(0, vecs[v].src, 8'h5A);
      fill(0, 16'hFE00, 256, 8'h00);
      drop_idx = vecs[v].drop_idx;
      drop_len = vecs[v].drop_len;
      run_xfer(vecs[v].src, 160, 16'hFE00);
      chk("vec_busy_cycles", bcnt, vecs[v].exp_busy);
      chk("vec_done_count", dcnt, 1);
      chk("vec_done_cycle", dcyc, vecs[v].exp_busy + 1);
      chk_dest("vec_dest_data", 16'hFE00, 0, 160, 8'h5A, 1'b1);
      chk_dest("vec_dest_tail", 16'hFE00, 160, 256, 8'h00, 1'b0);
    end
    drop_idx = -1;

    // Start strobe while busy, during the WRITE of idx 50.
    init_src(0, 8'hC0, 8'h5A);
    init_src(0, 8'hD0, 8'hA5);
    fill(0, 16'hFE00, 160, 8'h00);
    inj_idx = 50; inj_src = 8'hD0;
    run_xfer(8'hC0, 160, 16'hFE00);
    inj_idx = -1;
    chk("restart_done_count", dcnt, 1);
`ifdef IO_DMA_RESTART_EN
    chk("restart_busy_cycles", bcnt, 422);
    chk("restart_done_cycle", dcyc, 423);
    chk_dest("restart_dest", 16'hFE00, 0, 160, 8'hA5, 1'b1);
`else
    chk("ignore_busy_cycles", bcnt, 320);
    chk("ignore_done_cycle", dcyc, 321);
    chk_dest("ignore_dest", 16'hFE00, 0, 160, 8'h5A, 1'b1);
`endif

    // Async reset during READ of idx 80.
    init_src(0, 8'hC0, 8'h5A);
    fill(0, 16'hFE00, 160, 8'hEE);
    rst_idx = 80;
    run_xfer(8'hC0, 160, 16'hFE00);
    rst_idx = -1;
    chk("rst_abort_seen", aborted, 1'b1);
    chk("rst_writes_before", wcnt, 80);
    rq.delete();
    wq.delete();
    repeat (2) step(1'b0, 8'h00);
    rst_n = 1'b1;
    bcnt = 0; dcnt = 0;
    repeat (40) step(1'b0, 8'h00);
    chk("post_rst_busy", bcnt, 0);
    chk("post_rst_done", dcnt, 0);
    chk_dest("rst_dest_head", 16'hFE00, 0, 80, 8'h5A, 1'b1);
    chk_dest("rst_dest_tail", 16'hFE00, 80, 160, 8'hEE, 1'b0);

    // 256-byte transfer whose source ends at FFFF and destination wraps FFFF -> 0000.
    cur = 1;
    init_src(1, 8'hFF, 8'h3C);
    for (int i = 0; i < 128; i++) mem[1][16'(i)] = 8'h00;
    run_xfer(8'hFF, 256, 16'hFF80);
    chk("wrap_busy_cycles", bcnt, 512);
    chk("wrap_done_count", dcnt, 1);
    chk("wrap_done_cycle", dcyc, 513);
    chk("wrap_dst_ff80", mem[1][16'hFF80], 8'h3C);
    chk("wrap_dst_0000", mem[1][16'h0000], 8'h3C);
    chk("wrap_dst_007f", mem[1][16'h007F], 8'h43);
    chk("wrap_idle_a", busy0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
